// File: rtl/manchester_pkg.sv
// Shared Manchester definitions: decoder FSM states and half-bit symbol encodings
// (the symbol encodings are shared with the NRZ-to-Manchester encoder).
package manchester_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        H1   = 2'd1,
        H2   = 2'd2
    } state_t;

    // {first half-bit, second half-bit}
    localparam logic [1:0] MAN_ONE  = 2'b10;
    localparam logic [1:0] MAN_ZERO = 2'b01;

    function automatic logic sym_ok(input logic first_half, input logic second_half);
        return ({first_half, second_half} == MAN_ONE) || ({first_half, second_half} == MAN_ZERO);
    endfunction

endpackage

// File: rtl/manchester_sync2.sv
// Two-flop synchronizer for a Manchester line arriving from another clock domain.
module manchester_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/manchester_dec.sv
// Manchester-to-NRZ decoder with half-bit alignment hunt and loss-of-lock on repeated violations.
// Define MANCHESTER_DEC_SYNC_EN to insert a 2-flop synchronizer on man (adds 2 cycles of latency).
module manchester_dec
    import manchester_pkg::*;
#(
    parameter int unsigned ERR_LIMIT = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             man,
    output logic             nrz,
    output logic             valid,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

    logic       man_s;
    logic       man_q;
    logic       prev;
    logic       first;
    logic       seen_tr;
    logic [3:0] viol;
    state_t     state;

`ifdef MANCHESTER_DEC_SYNC_EN
    manchester_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (man),
        .q   (man_s)
    );
`else
    assign man_s = man;
`endif

    // locked is written in every branch with the value matching the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            man_q   <= '0;
            prev    <= '0;
            first   <= '0;
            seen_tr <= '0;
            viol    <= '0;
            state   <= HUNT;
            nrz     <= '0;
            valid   <= '0;
            err     <= '0;
            locked  <= '0;
            err_cnt <= '0;
        end else begin
            man_q <= man_s;
            prev  <= man_q;
            valid <= '0;
            err   <= '0;
            case (state)
                HUNT: begin
                    if (man_q != prev)
                        seen_tr <= '1;
                    // Equal adjacent half-bits after a transition can only straddle a bit boundary.
                    if (seen_tr && (man_q == prev)) begin
                        first  <= man_q;
                        viol   <= '0;
                        state  <= H2;
                        locked <= '1;
                    end else begin
                        locked <= '0;
                    end
                end
                H1: begin
                    first  <= man_q;
                    state  <= H2;
                    locked <= '1;
                end
                H2: begin
                    if (sym_ok(first, man_q)) begin
                        nrz    <= first;
                        valid  <= '1;
                        viol   <= '0;
                        state  <= H1;
                        locked <= '1;
                    end else begin
                        err <= '1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + CNT_W'(1);
                        if ((viol + 4'd1) == LIMIT) begin
                            state   <= HUNT;
                            seen_tr <= '0;
                            viol    <= '0;
                            locked  <= '0;
                        end else begin
                            viol   <= viol + 4'd1;
                            state  <= H1;
                            locked <= '1;
                        end
                    end
                end
                default: begin
                    state   <= HUNT;
                    seen_tr <= '0;
                    viol    <= '0;
                    locked  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_dec.sv
// Directed bench for manchester_dec: two instances (CNT_W=8 and CNT_W=2) on one shared line.
module tb_manchester_dec;
    import manchester_pkg::*;

    logic       clk = 0;
    logic       rst = 1;
    logic       man = 0;
    logic       nrz, valid, err, locked;
    logic [7:0] err_cnt;
    logic       nrz2, valid2, err2, locked2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int errs   = 0;
    int unl    = 0;
    int clash  = 0;
    logic vq[$];
    int   sq[$];

    always #5 clk = ~clk;

    manchester_dec #(.ERR_LIMIT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .man(man), .nrz(nrz), .valid(valid),
        .err(err), .locked(locked), .err_cnt(err_cnt)
    );

    manchester_dec #(.ERR_LIMIT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .man(man), .nrz(nrz2), .valid(valid2),
        .err(err2), .locked(locked2), .err_cnt(err_cnt2)
    );

    // Records strobes 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            if (valid) begin vq.push_back(nrz); sq.push_back(cyc); end
            if (err) begin errs++; sq.push_back(cyc); end
            if (valid && err) clash++;
            if (!locked) unl++;
        end
    end

    task automatic clear_log();
        vq.delete(); sq.delete();
        errs = 0; unl = 0; clash = 0;
    endtask

    task automatic half(input logic b);
        @(negedge clk);
        man = b;
    endtask

    task automatic sym(input logic a, input logic b);
        half(a);
        half(b);
    endtask

    task automatic send_bit(input logic d);
        logic [1:0] s;
        s = d ? MAN_ONE : MAN_ZERO;
        sym(s[1], s[0]);
    endtask

    task automatic test_reset();
        rst = 1; man = 0;
        repeat (2) @(negedge clk);
        checks++; if (nrz !== 1'b0) $display("FAIL reset_nrz: got %0b expected 0", nrz); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %0b expected 0", err); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", locked); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); else passed++;
        rst = 0;
    endtask

    task automatic test_idle();
        logic any;
        any = 0;
        repeat (40) begin
            half(1'b0);
            any = any | locked | valid | err;
        end
        checks++; if (any !== 1'b0) $display("FAIL idle_quiet: got %0b expected 0", any); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL idle_err_cnt: got %0d expected 0", err_cnt); else passed++;
    endtask

    task automatic test_payload();
        logic exp_bits [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int bad;
        send_bit(1);
        clear_log();
        send_bit(0);
        send_bit(1);
        checks++; if (locked !== 1'b1) $display("FAIL payload_locked: got %0b expected 1", locked); else passed++;
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        send_bit(1);
        checks++; if (vq.size() !== 6) $display("FAIL payload_count: got %0d expected 6", vq.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            if (i < vq.size()) begin
                checks++;
                if (vq[i] !== exp_bits[i]) $display("FAIL payload_bit%0d: got %0b expected %0b", i, vq[i], exp_bits[i]);
                else passed++;
            end
        end
        checks++; if (errs !== 0) $display("FAIL payload_err: got %0d expected 0", errs); else passed++;
        bad = 0;
        for (int i = 1; i < sq.size(); i++) if (sq[i] - sq[i-1] != 2) bad++;
        checks++; if (bad !== 0) $display("FAIL payload_spacing: got %0d bad gaps expected 0", bad); else passed++;
    endtask

    task automatic test_single_viol();
        int bad;
        send_bit(1);
        clear_log();
        sym(1, 1);
        send_bit(1);
        send_bit(0);
        send_bit(1);
        checks++; if (errs !== 1) $display("FAIL single_err_pulses: got %0d expected 1", errs); else passed++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); else passed++;
        checks++; if (unl !== 0) $display("FAIL single_lock_held: got %0d unlocked cycles expected 0", unl); else passed++;
        checks++; if (clash !== 0) $display("FAIL single_clash: got %0d expected 0", clash); else passed++;
        checks++;
        if (vq.size() !== 3 || vq[0] !== 1'b1 || vq[1] !== 1'b1 || vq[2] !== 1'b0)
            $display("FAIL single_bits: got %0d bits expected 1,1,0", vq.size());
        else passed++;
        bad = 0;
        for (int i = 1; i < sq.size(); i++) if (sq[i] - sq[i-1] != 2) bad++;
        checks++; if (bad !== 0 || sq.size() !== 4) $display("FAIL single_spacing: got %0d bad gaps of %0d strobes expected 0 of 4", bad, sq.size()); else passed++;
    endtask

    task automatic test_double_viol();
        send_bit(0);
        clear_log();
        sym(0, 0);
        sym(0, 0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        send_bit(1);
        checks++; if (errs !== 2) $display("FAIL double_err_pulses: got %0d expected 2", errs); else passed++;
        checks++; if (err_cnt !== 8'd3) $display("FAIL double_err_cnt: got %0d expected 3", err_cnt); else passed++;
        checks++; if ((unl > 0) !== 1'b1) $display("FAIL double_lock_lost: got %0d unlocked cycles expected >0", unl); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL double_relock: got %0b expected 1", locked); else passed++;
        checks++;
        if (vq.size() !== 5 || vq[0] !== 1'b0 || vq[1] !== 1'b0 || vq[2] !== 1'b1 || vq[3] !== 1'b1 || vq[4] !== 1'b0)
            $display("FAIL double_bits: got %0d bits expected 0,0,1,1,0", vq.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        send_bit(1);
        clear_log();
        @(negedge clk);
        man = 0;
        rst = 1;
        #1;
        checks++; if (nrz !== 1'b0) $display("FAIL midrst_nrz: got %0b expected 0", nrz); else passed++;
        checks++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %0b expected 0", valid); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL midrst_err: got %0b expected 0", err); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL midrst_locked: got %0b expected 0", locked); else passed++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); else passed++;
        checks++; if (err_cnt2 !== 2'd0) $display("FAIL midrst_err_cnt2: got %0d expected 0", err_cnt2); else passed++;
        @(negedge clk);
        rst = 0;
        man = 1;
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        send_bit(1);
        checks++;
        if (vq.size() !== 4 || vq[0] !== 1'b1 || vq[1] !== 1'b0 || vq[2] !== 1'b0 || vq[3] !== 1'b1)
            $display("FAIL midrst_bits: got %0d bits expected 1,0,0,1", vq.size());
        else passed++;
        checks++; if (errs !== 0) $display("FAIL midrst_err_pulses: got %0d expected 0", errs); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL midrst_relock: got %0b expected 1", locked); else passed++;
    endtask

    task automatic test_saturate();
        send_bit(1);
        clear_log();
        for (int r = 0; r < 5; r++) begin
            sym(1, 1);
            send_bit(0);
            if (r == 1) begin
                checks++; if (err_cnt2 !== 2'd2) $display("FAIL sat_err_cnt2_mid: got %0d expected 2", err_cnt2); else passed++;
            end
        end
        send_bit(1);
        checks++; if (errs !== 5) $display("FAIL sat_err_pulses: got %0d expected 5", errs); else passed++;
        checks++; if (err_cnt !== 8'd5) $display("FAIL sat_err_cnt: got %0d expected 5", err_cnt); else passed++;
        checks++; if (err_cnt2 !== 2'd3) $display("FAIL sat_err_cnt2: got %0d expected 3", err_cnt2); else passed++;
        checks++; if (unl !== 0) $display("FAIL sat_lock_held: got %0d unlocked cycles expected 0", unl); else passed++;
        checks++; if (vq.size() !== 6) $display("FAIL sat_valid_count: got %0d expected 6", vq.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_payload();
        test_single_viol();
        test_double_viol();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
